// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported 32-bit memory between the instruction-fetch port
//   and the data (load/store) port. One transaction at a time: a grant is
//   decided, the access is issued for one cycle, the fixed read latency is
//   counted down, and the response is returned to the owning requester.
//   The data port has fixed priority. Fetch is forced to win after losing
//   STARVE_MAX consecutive decisions while it was requesting.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req_i/addr_i   fetch request and byte address
//   if_gnt_o          fetch accepted this cycle (low = stall)
//   if_rvalid_o/rdata fetch response pulse and instruction word
//   d_req_i/we/addr/wdata/be  data request (store when we=1)
//   d_gnt_o           data accepted this cycle (low = stall)
//   d_rvalid_o/rdata  data response / write-ack pulse and load word
//   mem_*_o           memory strobe, write enable, address, write data, byte enables
//   mem_rdata_i       memory read data, valid LAT cycles after mem_en_o
//   busy_o            a transaction is in flight
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [3:0]        d_be_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              owner_data;   // 1 = data port owns the transaction
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        lat_cnt;
    logic [SW-1:0]     starve;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;

    logic decide;
    logic fetch_win;
    logic data_win;
    logic issue;
    logic resp;

    // Grants are only offered on decision cycles and never while reset is held,
    // so a requester cannot see a grant that the registers then discard.
    assign decide    = !rst && (state == IDLE || state == RESP);
    assign fetch_win = decide && if_req_i && (!d_req_i || starve == SW'(STARVE_MAX));
    assign data_win  = decide && d_req_i && !fetch_win;
    assign issue     = !rst && state == ISSUE;
    assign resp      = !rst && state == RESP;

    assign if_gnt_o    = fetch_win;
    assign d_gnt_o     = data_win;
    assign if_rvalid_o = resp && !owner_data;
    assign d_rvalid_o  = resp && owner_data;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign busy_o      = !rst && state != IDLE;

    // Memory side is only driven during the single issue cycle.
    assign mem_en_o    = issue;
    assign mem_we_o    = issue && we_q;
    assign mem_addr_o  = issue ? addr_q  : '0;
    assign mem_wdata_o = issue ? wdata_q : '0;
    assign mem_be_o    = issue ? be_q    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            lat_cnt    <= '0;
            starve     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (fetch_win) begin
                        owner_data <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= if_addr_i;
                        wdata_q    <= '0;
                        be_q       <= 4'b1111;
                        state      <= ISSUE;
                    end else if (data_win) begin
                        owner_data <= 1'b1;
                        we_q       <= d_we_i;
                        addr_q     <= d_addr_i;
                        wdata_q    <= d_wdata_i;
                        be_q       <= d_be_i;
                        state      <= ISSUE;
                    end else begin
                        state      <= IDLE;
                    end
                    // Fetch lost while asking: one step closer to a forced win.
                    if (if_req_i && data_win) begin
                        if (starve != SW'(STARVE_MAX))
                            starve <= starve + SW'(1);
                    end else begin
                        starve <= '0;
                    end
                end
                ISSUE: begin
                    lat_cnt <= 3'(LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    // Count of 1 marks the cycle the memory word is valid.
                    if (lat_cnt == 3'd1) begin
                        if (!owner_data)
                            if_rdata_q <= mem_rdata_i;
                        else if (!we_q)
                            d_rdata_q <= mem_rdata_i;
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (LAT=2, STARVE_MAX=4).
// Directed cycle-by-cycle stimulus; a small memory model returns a fixed word
// per address two cycles after each mem_en_o.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [31:0]       d_wdata_i;
    logic [3:0]        d_be_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_rdata_i;
    logic              busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
        case (a)
            10'h010: memword = 32'h0050_0093;
            10'h020: memword = 32'h1111_2222;
            10'h000: memword = 32'hA000_0000;
            10'h004: memword = 32'hA000_0004;
            10'h008: memword = 32'hA000_0008;
            default: memword = 32'hCAFE_0000 | 32'(a);
        endcase
    endfunction

    // Memory model: word valid exactly two cycles after the strobe cycle.
    logic              en_d1 = 1'b0, en_d2 = 1'b0;
    logic [ADDR_W-1:0] a_d1 = '0, a_d2 = '0;
    always @(posedge clk) begin
        en_d1 <= mem_en_o;
        a_d1  <= mem_addr_o;
        en_d2 <= en_d1;
        a_d2  <= a_d1;
    end
    assign mem_rdata_i = en_d2 ? memword(a_d2) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [ADDR_W-1:0] addrs [3];
    logic              exp_dgnt, exp_fgnt, exp_en, exp_rv;

    initial begin
        addrs[0] = 10'h000; addrs[1] = 10'h004; addrs[2] = 10'h008;
        rst = 1'b1; if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0;
        d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        tick(); tick();
        tick(); rst = 1'b0;
        settle();
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_busy",   32'(busy_o), 32'd0);
        check("rst_gnts",   32'({if_gnt_o, d_gnt_o}), 32'd0);
        check("rst_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
        check("rst_if_rdata", if_rdata_o, 32'd0);
        check("rst_d_rdata",  d_rdata_o, 32'd0);

        // 1: fetch only
        tick(); if_req_i = 1; if_addr_i = 10'h010;
        settle();
        check("t1_if_gnt", 32'(if_gnt_o), 32'd1);
        check("t1_d_gnt",  32'(d_gnt_o), 32'd0);
        tick(); if_req_i = 0;
        settle();
        check("t1_mem_en",   32'(mem_en_o), 32'd1);
        check("t1_mem_addr", 32'(mem_addr_o), 32'h010);
        check("t1_mem_we",   32'(mem_we_o), 32'd0);
        check("t1_mem_be",   32'(mem_be_o), 32'hF);
        check("t1_mem_wdata", mem_wdata_o, 32'd0);
        check("t1_busy",     32'(busy_o), 32'd1);
        tick(); settle();
        check("t1_en_off",   32'(mem_en_o), 32'd0);
        tick(); settle();
        check("t1_rv_early", 32'(if_rvalid_o), 32'd0);
        tick(); settle();
        check("t1_if_rvalid", 32'(if_rvalid_o), 32'd1);
        check("t1_if_rdata",  if_rdata_o, 32'h0050_0093);
        check("t1_d_rvalid",  32'(d_rvalid_o), 32'd0);
        tick(); settle();
        check("t1_rv_drop", 32'(if_rvalid_o), 32'd0);
        check("t1_idle",    32'(busy_o), 32'd0);

        // 2: simultaneous requests, data first
        tick(); if_req_i = 1; d_req_i = 1; d_we_i = 0; d_addr_i = 10'h020;
        settle();
        check("t2_d_gnt",  32'(d_gnt_o), 32'd1);
        check("t2_if_gnt", 32'(if_gnt_o), 32'd0);
        tick(); d_req_i = 0;
        settle();
        check("t2_mem_addr", 32'(mem_addr_o), 32'h020);
        check("t2_if_gnt_issue", 32'(if_gnt_o), 32'd0);
        tick(); tick(); settle();
        check("t2_if_gnt_wait", 32'(if_gnt_o), 32'd0);
        tick(); settle();
        check("t2_d_rvalid", 32'(d_rvalid_o), 32'd1);
        check("t2_d_rdata",  d_rdata_o, 32'h1111_2222);
        check("t2_if_gnt_resp", 32'(if_gnt_o), 32'd1);
        tick(); if_req_i = 0;
        settle();
        check("t2_f_mem_en",   32'(mem_en_o), 32'd1);
        check("t2_f_mem_addr", 32'(mem_addr_o), 32'h010);
        tick(); tick(); tick(); settle();
        check("t2_if_rvalid", 32'(if_rvalid_o), 32'd1);
        check("t2_if_rdata",  if_rdata_o, 32'h0050_0093);

        // 3: store
        tick(); d_req_i = 1; d_we_i = 1; d_addr_i = 10'h044;
        d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
        settle();
        check("t3_d_gnt", 32'(d_gnt_o), 32'd1);
        tick(); d_req_i = 0; d_we_i = 0;
        settle();
        check("t3_mem_we",    32'(mem_we_o), 32'd1);
        check("t3_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("t3_mem_be",    32'(mem_be_o), 32'h3);
        check("t3_mem_addr",  32'(mem_addr_o), 32'h044);
        check("t3_busy_t1",   32'(busy_o), 32'd1);
        tick(); tick(); settle();
        check("t3_busy_t3",   32'(busy_o), 32'd1);
        tick(); settle();
        check("t3_d_rvalid",  32'(d_rvalid_o), 32'd1);
        check("t3_d_rdata_held", d_rdata_o, 32'h1111_2222);
        check("t3_busy_t4",   32'(busy_o), 32'd1);
        tick(); settle();
        check("t3_busy_t5",   32'(busy_o), 32'd0);
        check("t3_rdata_after", d_rdata_o, 32'h1111_2222);

        // 4: starvation guard
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                if_req_i = 1; if_addr_i = 10'h010;
                d_req_i = 1; d_we_i = 0; d_addr_i = 10'h020;
            end
            settle();
            exp_fgnt = (k == 4);
            check($sformatf("t4_d_gnt_%0d", k),  32'(d_gnt_o),  32'(!exp_fgnt));
            check($sformatf("t4_if_gnt_%0d", k), 32'(if_gnt_o), 32'(exp_fgnt));
            if (k < 5) begin
                tick(); tick(); tick();
            end
        end
        tick(); if_req_i = 0; d_req_i = 0;
        tick(); tick(); tick(); tick(); settle();
        check("t4_idle", 32'(busy_o), 32'd0);

        // 5: reset aborts a load in flight
        tick(); d_req_i = 1; d_we_i = 0; d_addr_i = 10'h000;
        settle();
        check("t5_d_gnt", 32'(d_gnt_o), 32'd1);
        tick(); d_req_i = 0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        settle();
        check("t5_mem_en",   32'(mem_en_o), 32'd0);
        check("t5_busy",     32'(busy_o), 32'd0);
        check("t5_rvalids",  32'({if_rvalid_o, d_rvalid_o}), 32'd0);
        check("t5_d_rdata",  d_rdata_o, 32'd0);
        check("t5_if_rdata", if_rdata_o, 32'd0);
        check("t5_mem_addr", 32'(mem_addr_o), 32'd0);
        tick(); settle();
        check("t5_no_rvalid", 32'(d_rvalid_o), 32'd0);
        tick(); if_req_i = 1; if_addr_i = 10'h010;
        settle();
        check("t5_if_gnt", 32'(if_gnt_o), 32'd1);
        tick(); if_req_i = 0;
        settle();
        check("t5_f_mem_en", 32'(mem_en_o), 32'd1);
        tick(); tick(); tick(); settle();
        check("t5_if_rvalid", 32'(if_rvalid_o), 32'd1);
        check("t5_if_rdata",  if_rdata_o, 32'h0050_0093);
        check("t5_d_rvalid",  32'(d_rvalid_o), 32'd0);
        tick(); settle();
        check("t5_rv_drop",   32'(if_rvalid_o), 32'd0);

        // 6: back-to-back loads
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c == 0) begin
                d_req_i = 1; d_we_i = 0; d_addr_i = addrs[0];
            end else if (c == 1) begin
                d_addr_i = addrs[1];
            end else if (c == 5) begin
                d_addr_i = addrs[2];
            end else if (c == 9) begin
                d_req_i = 0;
            end
            settle();
            exp_dgnt = (c == 0 || c == 4 || c == 8);
            exp_en   = (c == 1 || c == 5 || c == 9);
            exp_rv   = (c == 4 || c == 8 || c == 12);
            check($sformatf("t6_d_gnt_%0d", c),  32'(d_gnt_o),  32'(exp_dgnt));
            check($sformatf("t6_mem_en_%0d", c), 32'(mem_en_o), 32'(exp_en));
            check($sformatf("t6_d_rv_%0d", c),   32'(d_rvalid_o), 32'(exp_rv));
            if (exp_en)
                check($sformatf("t6_mem_addr_%0d", c), 32'(mem_addr_o), 32'(addrs[c/4]));
            if (exp_rv)
                check($sformatf("t6_d_rdata_%0d", c), d_rdata_o, memword(addrs[c/4-1]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
